// File: rtl/ofifo_col_array.sv
// Per-column output FIFOs below the MAC array; a row is presented
// and popped only once every column holds data.
module ofifo_col_array #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf,
    output logic                   o_udf
);

    localparam int AW = $clog2(depth);

    logic [psum_bw-1:0] mem_q  [col][depth];
    logic [AW:0]        wptr_q [col];
    logic [AW:0]        wptr_d [col];
    logic [AW:0]        rptr_q [col];
    logic [AW:0]        rptr_d [col];
    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic [col-1:0]     wr_acc;
    logic               rd_acc;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    // Flags come from pointer registers only, never from wr/rd.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int c = 0; c < col; c++) begin
            empty[c] = (wptr_q[c] == rptr_q[c]);
            full[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                       (wptr_q[c][AW] != rptr_q[c][AW]);
        end
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~|full;
    assign rd_acc  = rd & o_valid;
    assign o_ovf   = ovf_q;
    assign o_udf   = udf_q;

    always_comb begin
        wr_acc = '0;
        out    = '0;
        for (int c = 0; c < col; c++) begin
            // A pop this cycle frees the slot a full column needs.
            wr_acc[c] = wr[c] & (~full[c] | rd_acc);
            wptr_d[c] = wptr_q[c] + (AW+1)'(wr_acc[c]);
            rptr_d[c] = rptr_q[c] + (AW+1)'(rd_acc);
            out[c*psum_bw +: psum_bw] =
                empty[c] ? '0 : mem_q[c][rptr_q[c][AW-1:0]];
        end
        ovf_d = ovf_q | (|(wr & ~wr_acc));
        udf_d = udf_q | (rd & ~o_valid);
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_acc[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

endmodule

// File: tb/tb_ofifo_col_array.sv
// Scoreboard bench for ofifo_col_array: stimulus queues expected rows,
// a negedge monitor pops and compares on every accepted read.
module tb_ofifo_col_array;

    logic         clk;
    logic         reset;
    logic [127:0] in;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] out;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic         o_ovf;
    logic         o_udf;

    int tests;
    int fails;
    logic [127:0] sb_q[$];

    ofifo_col_array #(
        .col    (8),
        .psum_bw(16),
        .depth  (64)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .wr     (wr),
        .rd     (rd),
        .out    (out),
        .o_valid(o_valid),
        .o_full (o_full),
        .o_ready(o_ready),
        .o_ovf  (o_ovf),
        .o_udf  (o_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkrow(input logic [15:0] base);
        logic [127:0] r;
        for (int c = 0; c < 8; c++) r[c*16 +: 16] = base + 16'(c);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: an accepted pop happens at the next edge.
    always @(negedge clk) begin
        if (!reset && rd && o_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", out);
            end else begin
                chk("pop_row", out, sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] r;
        reset = 1'b1;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;
        tick();
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_ready", 128'(o_ready), 128'(1));
        reset = 1'b0;
        tick();
        chk("idle_valid", 128'(o_valid), 128'(0));
        chk("idle_full", 128'(o_full), 128'(0));
        chk("idle_ready", 128'(o_ready), 128'(1));
        chk("idle_ovf", 128'(o_ovf), 128'(0));
        chk("idle_udf", 128'(o_udf), 128'(0));
        chk("idle_out", out, 128'(0));

        // Single aligned row
        wr = 8'hFF;
        in = mkrow(16'h0100);
        tick();
        wr = '0;
        chk("t1_valid", 128'(o_valid), 128'(1));
        chk("t1_out", out, mkrow(16'h0100));
        sb_q.push_back(mkrow(16'h0100));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t1_popped", 128'(o_valid), 128'(0));

        // Skewed column arrival
        for (int c = 0; c < 8; c++) begin
            wr = 8'(1 << c);
            in = mkrow(16'hA000);
            tick();
            chk("skew_valid", 128'(o_valid), 128'(c == 7));
        end
        wr = '0;
        sb_q.push_back(mkrow(16'hA000));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("skew_popped", 128'(o_valid), 128'(0));

        // Fill column 0
        wr = 8'h01;
        for (int i = 0; i < 64; i++) begin
            in = '0;
            in[15:0] = 16'(i);
            tick();
        end
        wr = '0;
        chk("fill_full", 128'(o_full), 128'(1));
        chk("fill_ready", 128'(o_ready), 128'(0));
        chk("fill_valid", 128'(o_valid), 128'(0));
        wr = 8'hFE;
        in = mkrow(16'h0B00);
        tick();
        chk("fill_valid2", 128'(o_valid), 128'(1));
        // Write into full column with a simultaneous pop
        r = mkrow(16'h0B00);
        r[15:0] = 16'h0000;
        sb_q.push_back(r);
        wr = 8'hFF;
        in = mkrow(16'h0C00);
        rd = 1'b1;
        tick();
        wr = '0;
        rd = 1'b0;
        chk("wrrd_full", 128'(o_full), 128'(1));
        chk("wrrd_ovf", 128'(o_ovf), 128'(0));
        chk("wrrd_valid", 128'(o_valid), 128'(1));
        wr = 8'h01;
        in = '0;
        in[15:0] = 16'hDEAD;
        tick();
        wr = '0;
        chk("ovf_set", 128'(o_ovf), 128'(1));
        chk("ovf_full", 128'(o_full), 128'(1));
        r = mkrow(16'h0C00);
        r[15:0] = 16'h0001;
        chk("ovf_head", out, r);
        do_reset();
        chk("ovf_cleared", 128'(o_ovf), 128'(0));

        // Streaming with wrap
        for (int k = 0; k < 200; k++) begin
            wr = 8'hFF;
            in = mkrow(16'(k * 8));
            rd = (k > 0);
            if (k > 0) sb_q.push_back(mkrow(16'((k - 1) * 8)));
            tick();
            if (o_valid !== 1'b1 || o_full !== 1'b0 || o_ready !== 1'b1 ||
                o_ovf !== 1'b0 || o_udf !== 1'b0) begin
                chk("wrap_flags",
                    {123'(0), o_valid, o_full, o_ready, o_ovf, o_udf},
                    128'b10100);
            end else begin
                tests++;
            end
        end
        wr = '0;
        sb_q.push_back(mkrow(16'(199 * 8)));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("wrap_drained", 128'(o_valid), 128'(0));

        // Read on empty
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("udf_set", 128'(o_udf), 128'(1));
        chk("udf_out", out, 128'(0));
        chk("udf_valid", 128'(o_valid), 128'(0));
        wr = 8'hFF;
        in = mkrow(16'h7700);
        rd = 1'b1;
        tick();
        wr = '0;
        rd = 1'b0;
        chk("emptywr_valid", 128'(o_valid), 128'(1));
        sb_q.push_back(mkrow(16'h7700));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("emptywr_popped", 128'(o_valid), 128'(0));

        // Asynchronous reset while holding rows
        wr = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            in = mkrow(16'(16'h3000 + i * 8));
            tick();
        end
        wr = '0;
        chk("hold_valid", 128'(o_valid), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 128'(o_valid), 128'(0));
        chk("arst_ovf", 128'(o_ovf), 128'(0));
        chk("arst_udf", 128'(o_udf), 128'(0));
        chk("arst_out", out, 128'(0));
        #2;
        reset = 1'b0;
        wr = 8'hFF;
        in = mkrow(16'h5550);
        tick();
        wr = '0;
        chk("post_valid", 128'(o_valid), 128'(1));
        chk("post_out", out, mkrow(16'h5550));
        sb_q.push_back(mkrow(16'h5550));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        chk("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofifo_col_array.md
# ofifo_col_array

Output collection buffer directly downstream of the MAC tile array. It captures each column's partial sum from the bottom row of tiles (`out_s`) into a per-column FIFO, independently timed per column, because skewed dataflow makes columns finish on different cycles. It presents a column-aligned output word only when every column holds data. It then pops all columns together for the accumulation/SFP stage.

## Interface
- `col`, default 8: number of array columns (one FIFO each)
- `psum_bw`, default 16: partial-sum width per column, matches tile `out_s`
- `depth`, default 64: entries per column FIFO; power of two, ≥ 2

- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-high; clears all state immediately
- `in` input col*psum_bw: column c psum at bits [c*psum_bw +: psum_bw]
- `wr` input col: per-column write strobe, bit c writes column c
- `rd` input 1: pop one aligned row from all columns
- `out` output col*psum_bw: head entry of every column, same packing as `in`
- `o_valid` output 1: every column non-empty
- `o_full` output 1: any column full
- `o_ready` output 1: no column full (= ~o_full)
- `o_ovf` output 1: sticky, a write was dropped
- `o_udf` output 1: sticky, a read was issued while `o_valid` low

## Operation
- Per column: `depth`-entry storage, write pointer, read pointer, occupancy.
  - Pointers are log2(depth)+1 bits; the extra MSB is a wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
- Write to column c:
  - Accepted when `wr[c]`=1 and (column c not full, or an accepted read pops this cycle).
  - An accepted write stores `in[c]` at wptr and increments wptr, wrapping modulo 2·depth.
  - A rejected write leaves storage and pointers unchanged and sets `o_ovf`.
- Read:
  - Accepted when `rd`=1 and `o_valid`=1.
  - An accepted read increments every column's rptr in the same cycle.
  - `rd`=1 with `o_valid`=0 changes no pointer and sets `o_udf`.
- `out`: combinational view of each column's head (first-word fall-through).
  - Defined only while `o_valid`=1.
  - Driven to 0 when the column is empty.
- Columns are independent for writing. Any subset of `wr` bits may be set in a cycle.
- Data is stored unmodified. No sign extension, no arithmetic.
- `o_ovf` and `o_udf` clear only on `reset`.

## Timing
- Reset values:
  - all pointers 0
  - `o_valid`=0, `o_full`=0, `o_ready`=1
  - `o_ovf`=0, `o_udf`=0
  - `out`=0
- Write latency: data written at edge N is visible on `out` (if its column was empty) and counted for `o_valid` right after edge N. Minimum write-to-read is 1 cycle.
- `o_valid`, `o_full`, `o_ready`: combinational from pointer registers only. They never depend on the current `wr`/`rd`, so there are no combinational paths from inputs to flags.
- Full column with simultaneous write + accepted read: both happen, occupancy stays at `depth`, `o_ovf` unchanged.
- Empty column with write + `rd` in the same cycle: the read is rejected (`o_valid` was 0) and `o_udf` is set. The write is accepted.
- Wrap-around: after 2·depth accepted writes, wptr returns to 0. Full and empty detection stay correct across any number of wraps.
- Throughput: one write per column and one aligned read per cycle, sustained.
- Reset mid-operation:
  - All pointers and flags clear asynchronously, without waiting for a clock edge.
  - Buffered data is discarded.
  - `o_valid` drops in the same cycle reset asserts.
  - The first write after reset deassertion is accepted on the next rising edge.

## Test plan
- Reset, then drive `wr`=8'hFF with column c = 16'h0100+c for one cycle, then `rd`=1.
  - Expect `o_valid`=1 one cycle after the write.
  - Expect `out` column c = 16'h0100+c.
  - Expect `o_valid`=0 after the pop.
- Skew: write column c at cycle c (c=0..7), value 16'hA000+c.
  - Expect `o_valid` to rise only after the column-7 write.
  - Expect all eight values to pop together on one `rd`.
- Fill column 0 with 64 writes (other columns idle): `o_full`=1, `o_ready`=0. Then:
  - A 65th write is dropped and `o_ovf`=1.
  - Write + `rd` on the full FIFO (all columns holding data) keeps occupancy at 64 with no new `o_ovf` event.
- Wrap: stream 200 rows with concurrent read and write, values incrementing from 0.
  - Expect popped rows in exact order with no loss.
  - Expect flags correct throughout.
- `rd`=1 on the empty FIFO: pointers unchanged, `o_udf`=1, `out`=0.
- Assert `reset` asynchronously (between clock edges) while holding 10 rows.
  - Expect `o_valid`=0, `o_ovf`=0, and `o_udf`=0 immediately, before the next edge.
  - A subsequent single write yields that value on `out`.
